// File: rtl/nes_pkg.sv
// ---------------------------------------------------------------------------
// nes_pkg
// Shared definitions for the NES controller receiver:
//   - button bit positions inside the 8-bit button vector
//   - poll FSM state encoding
//   - small helper for sizing counters from the timing parameters
// ---------------------------------------------------------------------------
package nes_pkg;

    // Bit positions in the active-high button vector (controller shift order)
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NUM_BUTTONS = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } nes_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nes_receiver_if.sv
// ---------------------------------------------------------------------------
// nes_receiver_if
// Host-side bundle of the NES receiver (the frame logic that requests polls
// and consumes button state).
//   poll    : single-cycle poll request (frame_end), host -> receiver
//   buttons : 8-bit active-high button state,       receiver -> host
//   valid   : one-cycle pulse when a poll completes, receiver -> host
//   busy    : high while a poll is in progress,      receiver -> host
// Modports: master = host side, slave = receiver side.
// ---------------------------------------------------------------------------
interface nes_receiver_if;
    import nes_pkg::*;

    logic                   poll;
    logic [NUM_BUTTONS-1:0] buttons;
    logic                   valid;
    logic                   busy;

    modport master (
        output poll,
        input  buttons,
        input  valid,
        input  busy
    );

    modport slave (
        input  poll,
        output buttons,
        output valid,
        output busy
    );

endinterface

// File: rtl/nes_sync.sv
// ---------------------------------------------------------------------------
// nes_sync
// Multi-flop synchroniser for the asynchronous controller data line.
// Resets to 1 so that a released/unplugged line reads as "not pressed".
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module nes_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;
    logic [STAGES-1:0] stage_next;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_next[gi] = d;
            end else begin : g_chain
                assign stage_next[gi] = stage_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_reg <= '1;
        end else begin
            stage_reg <= stage_next;
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/nes_receiver.sv
// ---------------------------------------------------------------------------
// nes_receiver
// Polls an NES controller once per request: pulses the latch line, then
// issues 8 shift clocks and samples the serial data (A first). The 8 bits
// are presented as a registered active-high button vector, updated
// atomically when the poll completes.
//
// Parameters:
//   HALF_PERIOD  : clk cycles per nes_clk half period (>= 4)
//   LATCH_CYCLES : clk cycles nes_latch is held high   (>= 4)
// Ports:
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   host      : nes_receiver_if.slave (poll in; buttons/valid/busy out)
//   nes_data  : serial data from controller, active-low, asynchronous
//   nes_latch : controller latch strobe, active-high
//   nes_clk   : controller shift clock, idles low
//
// Build option: define NES_AGREE_FILTER_EN to only accept a new sample
// into buttons when it matches the sample from the previous completed poll.
// ---------------------------------------------------------------------------
module nes_receiver
    import nes_pkg::*;
#(
    parameter int HALF_PERIOD  = 150,
    parameter int LATCH_CYCLES = 300
) (
    input  logic          clk,
    input  logic          rst_n,
    nes_receiver_if.slave host,
    input  logic          nes_data,
    output logic          nes_latch,
    output logic          nes_clk
);

    localparam int CNT_W = $clog2(max_int(HALF_PERIOD, LATCH_CYCLES));
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_PERIOD - 1);

    nes_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2:0]             bit_reg, bit_next;
    logic [NUM_BUTTONS-1:0] shift_reg;
    logic [NUM_BUTTONS-1:0] buttons_reg;
    logic                   nes_latch_reg;
    logic                   nes_clk_reg;
    logic                   valid_reg;
    logic                   busy_reg;
    logic                   sample_bit;
    logic                   sync_data;
`ifdef NES_AGREE_FILTER_EN
    logic [NUM_BUTTONS-1:0] prev_sample_reg;
`endif

    nes_sync #(.STAGES(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nes_data),
        .q     (sync_data)
    );

    // Next-state logic. The counter restarts from zero on every state change,
    // so it only ever counts up to the length of the current phase.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        bit_next   = bit_reg;
        sample_bit = 1'b0;
        case (state_reg)
            IDLE: begin
                if (host.poll) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (cnt_reg == LATCH_LAST) begin
                    state_next = LOW;
                    bit_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LOW: begin
                if (cnt_reg == HALF_LAST) begin
                    // Data has been stable for the whole low phase; sample at its end.
                    state_next = HIGH;
                    sample_bit = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_reg == HALF_LAST) begin
                    if (bit_reg == 3'd7) begin
                        state_next = DONE;
                    end else begin
                        state_next = LOW;
                        bit_next   = bit_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                // A poll arriving here is dropped, not queued.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            buttons_reg   <= '0;
            nes_latch_reg <= 1'b0;
            nes_clk_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef NES_AGREE_FILTER_EN
            prev_sample_reg <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_reg       <= bit_next;
            nes_latch_reg <= (state_next == LATCH);
            nes_clk_reg   <= (state_next == HIGH);
            valid_reg     <= (state_next == DONE);
            busy_reg      <= (state_next != IDLE);

            // LSB-first: the first bit (A) ends up in bit 0 after 8 shifts.
            if (sample_bit) begin
                shift_reg <= {~sync_data, shift_reg[NUM_BUTTONS-1:1]};
            end

            if (state_next == DONE) begin
`ifdef NES_AGREE_FILTER_EN
                if (shift_reg == prev_sample_reg) begin
                    buttons_reg <= shift_reg;
                end
                prev_sample_reg <= shift_reg;
`else
                buttons_reg <= shift_reg;
`endif
            end
        end
    end

    assign nes_latch    = nes_latch_reg;
    assign nes_clk      = nes_clk_reg;
    assign host.buttons = buttons_reg;
    assign host.valid   = valid_reg;
    assign host.busy    = busy_reg;

endmodule
